adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
Synthesizable emulator for the ADC side of the CNV/BUSY/SCK/MISO acquisition interface. It is the device that the adc_read initiator talks to.
- On a cnv rising edge it latches a sample word, holds busy for a fixed conversion time, then shifts the word out MSB-first on the master's sck.
- Used on the acquisition board in loopback/self-test builds and as the ADC stand-in for system benches.

Parameters:
DATA_WIDTH, 16, bits per conversion result shifted out
CONV_CYCLES, 50, clk cycles busy stays high per conversion (>=1)
SYNC_STAGES, 2, flip-flop stages on the cnv and sck inputs (>=2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset
cnv  input  1  convert start from master; asynchronous to clk
sck  input  1  serial clock from master; asynchronous to clk
sample_data  input  DATA_WIDTH  value to report for the next conversion
sample_taken  output  1  one-cycle pulse when sample_data is latched
busy  output  1  conversion in progress (registered)
miso  output  1  serial data to master (registered)
frame_done  output  1  one-cycle pulse after the last bit has been clocked out
overrun  output  1  one-cycle pulse when cnv rises while not IDLE

Behaviour:
Reset (rst=0 at a clk edge):
- busy=0, miso=0, sample_taken=0, frame_done=0, overrun=0.
- State=IDLE, synchronizers cleared, bit counter=0.
- Reset applies in any state, including mid-conversion and mid-readout.

Input conditioning:
- cnv and sck each pass through SYNC_STAGES FFs plus one history FF.
- Edge detect: the cycle where the synced value differs from history.
- Master timing requirements:
  - sck high and low times >= SYNC_STAGES+2 clk periods.
  - cnv high time >= SYNC_STAGES+1 clk periods.

States:
- IDLE: miso=0, busy=0. sck edges ignored. On a cnv rise, go to CONVERT.
- Transition into CONVERT, in the same cycle:
  - latch sample_data into shift register;
  - pulse sample_taken;
  - load conversion counter with CONV_CYCLES-1;
  - busy=1 from the next edge.
- Latency: busy rises SYNC_STAGES+1 clk edges after the first edge that samples cnv=1.
- CONVERT: busy=1 for exactly CONV_CYCLES cycles.
  - A cnv rise pulses overrun and is otherwise ignored; the counter is not restarted.
  - sck edges are ignored.
  - At terminal count, go to SHIFT with busy=0 and miso=shift[DATA_WIDTH-1] in the same cycle.
- SHIFT:
  - Master samples miso on sck rising.
  - On each detected sck rise, increment the bit counter.
  - On each detected sck fall, shift left and drive the next bit on miso.
  - When the counter reaches DATA_WIDTH on a rise:
    - pulse frame_done;
    - go to IDLE;
    - miso=0 from the next cycle.
- cnv rise in SHIFT (readout aborted):
  - pulse overrun;
  - discard the remaining bits;
  - take the CONVERT entry actions immediately (new sample latched, sample_taken pulses).
  - overrun and sample_taken pulse in the same cycle.
- Simultaneous sck and cnv edges in SHIFT: cnv wins and the sck edge is dropped.
- Simultaneous last sck rise and cnv rise: cnv wins; no frame_done pulse; overrun pulses.

Width and wrap rules:
- Bit counter is clog2(DATA_WIDTH+1) bits and never wraps; it is cleared on CONVERT entry.
- Conversion counter is clog2(CONV_CYCLES) bits and counts down.
- Bits shifted in at the LSB are 0.

Decomposition:
- Shared package adc_if_pkg holds:
  - state encoding localparams (IDLE, CONVERT, SHIFT);
  - default DATA_WIDTH and CONV_CYCLES, so adc_read and this block agree on frame length.
- One sub-module: sync_edge (parameter SYNC_STAGES; ports clk, rst, d, q, rise, fall), instanced twice, for cnv and sck.

Test Plan:
1. Basic frame. sample_data=16'hA5C3, cnv pulse, wait for busy fall, 16 sck periods of 10 clk each. Required: sampled miso bits on sck rising = 1010010111000011; frame_done pulses once, 1 cycle after the 16th detected rise; miso=0 afterwards.
2. Conversion timing. CONV_CYCLES=50, cnv rises. Required: busy high exactly 50 cycles, starting 3 edges after cnv is sampled; sample_taken pulses once, 1 cycle before busy rises.
3. cnv during CONVERT. Second cnv pulse 20 cycles into busy. Required: overrun pulse of 1 cycle; busy still ends at 50 total; the first sample is shifted out unchanged.
4. cnv during SHIFT. After 5 bits of 16'hFFFF, set sample_data=16'h0001 and pulse cnv. Required: overrun and sample_taken pulse together; no frame_done; busy 50 cycles; then 0000000000000001 is shifted out.
5. Reset mid-readout. rst=0 for 1 cycle after 8 bits. Required: all outputs 0 on the next edge; sck edges then ignored; a fresh cnv gives a normal frame.
6. Idle sck. 20 sck periods with no cnv. Required: miso stays 0, busy stays 0, no pulses.

Source files
------------

// File: rtl/adc_if_pkg.sv
// ============================================================================
// adc_if_pkg : shared state encoding and frame defaults for the ADC interface
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_if_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_CONV_CYCLES = 50;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_CONVERT = CONVERT,
    ST_SHIFT   = SHIFT
  } state_t;

  // Counter width that stays legal for a count of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// sync_edge : multi-stage synchronizer with history FF and edge detection
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign q    = r_sync[SYNC_STAGES-1];
  assign rise = q & ~r_hist;
  assign fall = ~q & r_hist;

endmodule

`default_nettype wire

// File: rtl/adc_spi_responder.sv
// ============================================================================
// adc_spi_responder : ADC-side CNV/BUSY/SCK/MISO emulator (latch, convert, shift)
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_spi_responder
  import adc_if_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CONV_CYCLES = DEFAULT_CONV_CYCLES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cnv,
  input  logic                  sck,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_taken,
  output logic                  busy,
  output logic                  miso,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int CW = cnt_width(CONV_CYCLES);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bits;
  logic [CW-1:0]         r_conv;

  logic w_cnv_q, w_cnv_rise, w_cnv_fall;
  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_enter;
  logic w_unused_sync;
  logic [DATA_WIDTH-1:0] w_next_shift;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cnv_sync (
    .clk (clk), .rst (rst), .d (cnv),
    .q (w_cnv_q), .rise (w_cnv_rise), .fall (w_cnv_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk (clk), .rst (rst), .d (sck),
    .q (w_sck_q), .rise (w_sck_rise), .fall (w_sck_fall)
  );

  assign w_unused_sync = w_cnv_q ^ w_cnv_fall ^ w_sck_q;
  assign w_next_shift  = r_shift << 1;
  // A new conversion starts from IDLE or aborts a readout; in CONVERT it is only flagged.
  assign w_enter       = w_cnv_rise && (r_state != ST_CONVERT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bits       <= '0;
      r_conv       <= '0;
      busy         <= 1'b0;
      miso         <= 1'b0;
      sample_taken <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_taken <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= w_cnv_rise && (r_state != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          busy <= 1'b0;
          miso <= 1'b0;
        end
        ST_CONVERT: begin
          // First cycle only raises busy so that it stays high CONV_CYCLES cycles.
          if (!busy) begin
            busy <= 1'b1;
          end else if (r_conv == '0) begin
            busy    <= 1'b0;
            miso    <= r_shift[DATA_WIDTH-1];
            r_state <= ST_SHIFT;
          end else begin
            r_conv <= r_conv - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_sck_rise) begin
            r_bits <= r_bits + 1'b1;
            if (r_bits == BW'(DATA_WIDTH - 1)) begin
              frame_done <= 1'b1;
              miso       <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end else if (w_sck_fall) begin
            r_shift <= w_next_shift;
            miso    <= w_next_shift[DATA_WIDTH-1];
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Overrides any same-cycle sck action: cnv always wins.
      if (w_enter) begin
        r_shift      <= sample_data;
        sample_taken <= 1'b1;
        r_conv       <= CW'(CONV_CYCLES - 1);
        r_bits       <= '0;
        busy         <= 1'b0;
        miso         <= 1'b0;
        frame_done   <= 1'b0;
        r_state      <= ST_CONVERT;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
// ============================================================================
// tb_adc_spi_responder : directed vector bench for adc_spi_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cnv = 1'b0;
  logic        sck = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_taken, busy, miso, frame_done, overrun;

  always #5 clk = ~clk;

  adc_spi_responder #(.DATA_WIDTH(16), .CONV_CYCLES(50), .SYNC_STAGES(2)) dut (
    .clk (clk), .rst (rst), .cnv (cnv), .sck (sck),
    .sample_data (sample_data), .sample_taken (sample_taken), .busy (busy),
    .miso (miso), .frame_done (frame_done), .overrun (overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  int st_cnt = 0, ov_cnt = 0, fd_cnt = 0, both_cnt = 0, miso_hi = 0;
  int busy_run = 0, last_run = 0;

  always @(negedge clk) begin
    if (sample_taken) st_cnt++;
    if (overrun) ov_cnt++;
    if (frame_done) fd_cnt++;
    if (sample_taken && overrun) both_cnt++;
    if (miso) miso_hi++;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_word;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_cnv();
    @(negedge clk) cnv = 1'b1;
    repeat (4) @(negedge clk);
    cnv = 1'b0;
  endtask

  task automatic wait_busy_fall(output bit ok);
    bit seen;
    ok = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Master side: sck low 5 clk, sample miso, raise sck for 5 clk, lower.
  task automatic shift_bits(input int n, output logic [31:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      repeat (5) @(negedge clk);
      w = {w[30:0], miso};
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [15:0] data, output logic [31:0] w);
    bit ok;
    sample_data = data;
    pulse_cnv();
    wait_busy_fall(ok);
    check("busy_fall_timeout", 32'(ok), 32'd1);
    shift_bits(16, w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int st0, ov0, fd0, both0, mh0, cnt;
    bit ok;
    logic st_exp[4], busy_exp[4], fd_exp[4];

    tbl[0] = '{16'hA5C3, 16'b1010010111000011};
    tbl[1] = '{16'hFFFF, 16'b1111111111111111};
    tbl[2] = '{16'h0000, 16'b0000000000000000};
    tbl[3] = '{16'h8001, 16'b1000000000000001};
    tbl[4] = '{16'h7E18, 16'b0111111000011000};
    st_exp   = '{1'b0, 1'b0, 1'b1, 1'b0};
    busy_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
    fd_exp   = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, busy, miso, sample_taken, frame_done, overrun}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Conversion timing, cycle by cycle
    sample_data = 16'h5A96;
    cnv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("lat_sample_taken_e%0d", k + 1), 32'(sample_taken), 32'(st_exp[k]));
      check($sformatf("lat_busy_e%0d", k + 1), 32'(busy), 32'(busy_exp[k]));
    end
    cnv = 1'b0;
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    check("busy_length", 32'(cnt), 32'd50);
    shift_bits(15, w);
    repeat (5) @(negedge clk);
    w = {w[30:0], miso};
    sck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("frame_done_e%0d", k + 1), 32'(frame_done), 32'(fd_exp[k]));
    end
    @(negedge clk) sck = 1'b0;
    check("timing_frame_word", {16'd0, w[15:0]}, 32'h5A96);

    // Table-driven frames
    foreach (tbl[i]) begin
      fd0 = fd_cnt;
      st0 = st_cnt;
      do_frame(tbl[i].data, w);
      repeat (4) @(negedge clk);
      check($sformatf("frame%0d_word", i), {16'd0, w[15:0]}, {16'd0, tbl[i].exp_word});
      check($sformatf("frame%0d_done_count", i), 32'(fd_cnt - fd0), 32'd1);
      check($sformatf("frame%0d_taken_count", i), 32'(st_cnt - st0), 32'd1);
      check($sformatf("frame%0d_busy_len", i), 32'(last_run), 32'd50);
      check($sformatf("frame%0d_miso_after", i), 32'(miso), 32'd0);
    end

    // cnv during CONVERT
    sample_data = 16'h1234;
    st0 = st_cnt;
    ov0 = ov_cnt;
    pulse_cnv();
    sample_data = 16'hDEAD;
    repeat (16) @(negedge clk);
    pulse_cnv();
    wait_busy_fall(ok);
    check("conv_overrun_busy_timeout", 32'(ok), 32'd1);
    shift_bits(16, w);
    check("conv_overrun_count", 32'(ov_cnt - ov0), 32'd1);
    check("conv_overrun_taken_count", 32'(st_cnt - st0), 32'd1);
    check("conv_overrun_busy_len", 32'(last_run), 32'd50);
    check("conv_overrun_word", {16'd0, w[15:0]}, 32'h1234);

    // cnv during SHIFT
    sample_data = 16'hFFFF;
    pulse_cnv();
    wait_busy_fall(ok);
    check("abort_busy_timeout", 32'(ok), 32'd1);
    shift_bits(5, w);
    check("abort_first_bits", w, 32'h1F);
    sample_data = 16'h0001;
    st0 = st_cnt; ov0 = ov_cnt; fd0 = fd_cnt; both0 = both_cnt;
    pulse_cnv();
    wait_busy_fall(ok);
    check("abort_busy2_timeout", 32'(ok), 32'd1);
    shift_bits(16, w);
    repeat (4) @(negedge clk);
    check("abort_word", {16'd0, w[15:0]}, 32'h0001);
    check("abort_together", 32'(both_cnt - both0), 32'd1);
    check("abort_overrun", 32'(ov_cnt - ov0), 32'd1);
    check("abort_done_count", 32'(fd_cnt - fd0), 32'd1);
    check("abort_busy_len", 32'(last_run), 32'd50);

    // Reset mid-readout
    sample_data = 16'hC3A5;
    pulse_cnv();
    wait_busy_fall(ok);
    shift_bits(8, w);
    check("pre_reset_bits", w, 32'hC3);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {27'd0, busy, miso, sample_taken, frame_done, overrun}, 32'd0);
    rst = 1'b1;
    st0 = st_cnt; ov0 = ov_cnt; fd0 = fd_cnt; mh0 = miso_hi;
    shift_bits(8, w);
    check("post_reset_sck_miso", w, 32'd0);
    check("post_reset_pulses", 32'((st_cnt - st0) + (ov_cnt - ov0) + (fd_cnt - fd0)), 32'd0);
    check("post_reset_miso_hi", 32'(miso_hi - mh0), 32'd0);
    do_frame(16'h3C5A, w);
    repeat (4) @(negedge clk);
    check("post_reset_frame_word", {16'd0, w[15:0]}, 32'h3C5A);
    check("post_reset_done", 32'(fd_cnt - fd0), 32'd1);

    // Idle sck
    st0 = st_cnt; ov0 = ov_cnt; fd0 = fd_cnt; mh0 = miso_hi;
    shift_bits(20, w);
    check("idle_sck_miso", w, 32'd0);
    check("idle_sck_miso_hi", 32'(miso_hi - mh0), 32'd0);
    check("idle_sck_busy", 32'(busy), 32'd0);
    check("idle_sck_pulses", 32'((st_cnt - st0) + (ov_cnt - ov0) + (fd_cnt - fd0)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
